// File: rtl/gnn_0_example_weight_sched_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | gnn_0_example_weight_sched_pkg                                           |
// | Shared instruction layout and FSM encoding for the weight scheduler.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gnn_0_example_weight_sched_pkg;

    localparam int WEIGHT_INST_LENGTH = 96;

    localparam int C_BYTES_MSB        = 95;
    localparam int C_BYTES_LSB        = 80;
    localparam int C_DRAM_OFF_MSB     = 79;
    localparam int C_DRAM_OFF_LSB     = 64;
    localparam int C_BUF_LINE_MSB     = 63;
    localparam int C_BUF_LINE_LSB     = 48;
    localparam int C_BANK_BIT         = 32;
    localparam int C_SIGNAL_READY_BIT = 17;
    localparam int C_WAIT_RELEASE_BIT = 16;
    localparam int C_ID_MSB           = 15;
    localparam int C_ID_LSB           = 0;

    // Overlay of the 96-bit instruction; field order mirrors the bit positions above.
    typedef struct packed {
        logic [15:0] bytes;
        logic [15:0] dram_off;
        logic [15:0] buf_line;
        logic [14:0] rsvd_hi;
        logic        bank;
        logic [13:0] rsvd_lo;
        logic        signal_ready;
        logic        wait_release;
        logic [15:0] id;
    } weight_inst_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_BUSY   = 2'd2,
        ST_COMMIT = 2'd3
    } sched_state_t;

    function automatic logic inst_is_empty(input weight_inst_t inst);
        return inst.bytes == 16'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnn_0_example_inst_fifo.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | gnn_0_example_inst_fifo                                                  |
// | Show-ahead synchronous FIFO with count-based full/empty flags.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gnn_0_example_inst_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    import gnn_0_example_weight_sched_pkg::*;

    localparam int          C_AW    = $clog2(DEPTH);
    localparam logic [C_AW:0] C_FULL_CNT = (C_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == C_FULL_CNT);
    assign empty     = (r_count == '0);
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gnn_0_example_weight_sched.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | gnn_0_example_weight_sched                                               |
// | Queues weight-load instructions, drives the loader handshake and tracks  |
// | occupancy of the two-bank weight buffer.                                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gnn_0_example_weight_sched #(
    parameter int WEIGHT_INST_LENGTH = 96,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          kernel_clk,
    input  logic                          kernel_rst_n,
    input  logic                          inst_valid,
    output logic                          inst_ready,
    input  logic [WEIGHT_INST_LENGTH-1:0] inst_data,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cfg_base_addr,
    output logic                          ap_start,
    input  logic                          ap_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    output logic [WEIGHT_INST_LENGTH-1:0] ctrl_instruction,
    output logic                          wt_ready_valid,
    output logic                          wt_ready_bank,
    input  logic                          wt_release,
    input  logic                          wt_release_bank,
    output logic [1:0]                    bank_full,
    output logic                          sched_idle,
    output logic [15:0]                   done_count,
    output logic                          err
);
    import gnn_0_example_weight_sched_pkg::*;

    sched_state_t                   r_state;
    logic                           r_ap_start;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  r_addr_offset;
    logic [WEIGHT_INST_LENGTH-1:0]  r_ctrl_instruction;
    logic                           r_wt_ready_valid;
    logic                           r_wt_ready_bank;
    logic [1:0]                     r_bank_full;
    logic [15:0]                    r_done_count;
    logic                           r_err;

    logic [WEIGHT_INST_LENGTH-1:0]  w_fifo_head;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;
    weight_inst_t                   w_head;
    weight_inst_t                   w_cur;
    logic                           w_head_ok;
    logic                           w_pop;
    logic                           w_head_zero;
    logic                           w_commit_now;
    logic                           w_commit_bank;
    logic                           w_commit_signal;
    logic                           w_spurious_done;
    logic                           w_bad_release;
    logic [1:0]                     w_bank_full_nxt;

    gnn_0_example_inst_fifo #(
        .WIDTH (WEIGHT_INST_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk       (kernel_clk),
        .rst_n     (kernel_rst_n),
        .push      (inst_valid),
        .push_data (inst_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign w_head      = weight_inst_t'(w_fifo_head);
    assign w_cur       = weight_inst_t'(r_ctrl_instruction);
    assign w_head_zero = inst_is_empty(w_head);

    // A head that waits on its bank blocks everything behind it (in-order queue).
    assign w_head_ok = !w_head.wait_release || !r_bank_full[w_head.bank];
    assign w_pop     = (r_state == ST_IDLE) && !w_fifo_empty && w_head_ok;

    // Completion is recorded on the edge that enters COMMIT so the outputs
    // are visible during the COMMIT cycle itself.
    assign w_commit_now    = ((r_state == ST_BUSY) && ap_done) || (w_pop && w_head_zero);
    assign w_commit_bank   = (r_state == ST_BUSY) ? w_cur.bank : w_head.bank;
    assign w_commit_signal = (r_state == ST_BUSY) ? w_cur.signal_ready : w_head.signal_ready;

    assign w_spurious_done = ap_done && (r_state != ST_BUSY);
    assign w_bad_release   = wt_release && !r_bank_full[wt_release_bank];

    // Set beats a concurrent release, both on the completing edge and in COMMIT.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (wt_release) begin
            w_bank_full_nxt[wt_release_bank] = 1'b0;
        end
        if (w_commit_now) begin
            w_bank_full_nxt[w_commit_bank] = 1'b1;
        end
        if (r_state == ST_COMMIT) begin
            w_bank_full_nxt[w_cur.bank] = 1'b1;
        end
    end

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            r_state            <= ST_IDLE;
            r_ap_start         <= 1'b0;
            r_addr_offset      <= '0;
            r_ctrl_instruction <= '0;
            r_wt_ready_valid   <= 1'b0;
            r_wt_ready_bank    <= 1'b0;
            r_bank_full        <= 2'b00;
            r_done_count       <= 16'd0;
            r_err              <= 1'b0;
        end else begin
            r_ap_start       <= 1'b0;
            r_wt_ready_valid <= 1'b0;
            r_addr_offset    <= cfg_base_addr;
            r_bank_full      <= w_bank_full_nxt;
            r_err            <= r_err | w_spurious_done | w_bad_release;

            if (w_commit_now) begin
                r_done_count <= r_done_count + 16'd1;
                if (w_commit_signal) begin
                    r_wt_ready_valid <= 1'b1;
                    r_wt_ready_bank  <= w_commit_bank;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_ctrl_instruction <= w_fifo_head;
                        if (w_head_zero) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_state    <= ST_ISSUE;
                            r_ap_start <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (ap_done) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign inst_ready       = !w_fifo_full || w_pop;
    assign sched_idle       = w_fifo_empty && (r_state == ST_IDLE);
    assign ap_start         = r_ap_start;
    assign ctrl_addr_offset = r_addr_offset;
    assign ctrl_instruction = r_ctrl_instruction;
    assign wt_ready_valid   = r_wt_ready_valid;
    assign wt_ready_bank    = r_wt_ready_bank;
    assign bank_full        = r_bank_full;
    assign done_count       = r_done_count;
    assign err              = r_err;

endmodule
`default_nettype wire
